// File: rtl/pdes_disp_ctl.sv
// PDES dispatch controller: AEG register file, engine start/collect/abort sequencing, CSR reads.
// Optional run timeout enabled by defining PDES_DISP_TIMEOUT_EN.
module pdes_disp_ctl #(
    parameter int NA        = 16,
    parameter int NUM_ENG   = 4,
    parameter int NUM_STATS = 5
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          disp_inst_vld,
    input  logic [4:0]                    disp_inst,
    input  logic [17:0]                   disp_aeg_idx,
    input  logic                          disp_aeg_rd,
    input  logic                          disp_aeg_wr,
    input  logic [63:0]                   disp_aeg_wr_data,
    output logic [17:0]                   disp_aeg_cnt,
    output logic [15:0]                   disp_exception,
    output logic                          disp_idle,
    output logic                          disp_stall,
    output logic                          disp_rtn_data_vld,
    output logic [63:0]                   disp_rtn_data,
    output logic [NUM_ENG-1:0]            eng_start,
    output logic [NUM_ENG-1:0]            eng_abort,
    input  logic [NUM_ENG-1:0]            eng_done,
    input  logic [NUM_ENG*16-1:0]         eng_gvt,
    input  logic [NUM_ENG*NUM_STATS*64-1:0] eng_stats,
    output logic [255:0]                  eng_cfg,
    input  logic                          csr_rd_vld,
    input  logic [15:0]                   csr_address,
    output logic                          csr_rd_ack,
    output logic [63:0]                   csr_rd_data
);
    localparam int IW = $clog2(NA);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RUN     = 3'd2,
        COLLECT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [63:0]        aeg [NA];
    logic               caep00, caep01, caep00_p1;
    logic               idx_ok, abort_req, no_mask, timeout_hit;
    logic [IW-1:0]      idx;
    logic [NUM_ENG-1:0] mask, done_q, done_now;
    logic [15:0]        gvt_min;
    logic [63:0]        stat_sum [NUM_STATS];

    assign disp_aeg_cnt = 18'(NA);
    assign caep00       = disp_inst_vld && (disp_inst == 5'd0);
    assign caep01       = disp_inst_vld && (disp_inst == 5'd1);
    assign idx_ok       = disp_aeg_idx < 18'(NA);
    assign idx          = disp_aeg_idx[IW-1:0];
    assign mask         = aeg[4][NUM_ENG-1:0];
    assign done_now     = done_q | eng_done;
    assign eng_start    = (state == START) ? mask : '0;
    assign disp_idle    = (state == IDLE) && !caep00_p1;
    assign disp_stall   = (state != IDLE) || caep00 || caep00_p1;

    for (genvar i = 0; i < 4; i++) begin : g_cfg
        assign eng_cfg[i*64 +: 64] = aeg[i];
    end

`ifdef PDES_DISP_TIMEOUT_EN
    logic [31:0] to_cnt;

    always_ff @(posedge clk) begin
        if (i_reset)
            to_cnt <= '0;
        else if (state == START)
            to_cnt <= '0;
        else if (state == RUN)
            to_cnt <= to_cnt + 32'd1;
    end

    // Fires on the RUN cycle that completes the programmed count.
    assign timeout_hit = (state == RUN) && (aeg[5][31:0] != 32'd0) &&
                         ((to_cnt + 32'd1) == aeg[5][31:0]);
`else
    assign timeout_hit = 1'b0;
`endif

    // Reduction over masked engines: minimum GVT and wrap-around statistic sums.
    always_comb begin
        gvt_min = 16'hFFFF;
        for (int e = 0; e < NUM_ENG; e++)
            if (mask[e] && (eng_gvt[e*16 +: 16] < gvt_min))
                gvt_min = eng_gvt[e*16 +: 16];
        for (int k = 0; k < NUM_STATS; k++) begin
            stat_sum[k] = '0;
            for (int e = 0; e < NUM_ENG; e++)
                if (mask[e])
                    stat_sum[k] = stat_sum[k] + eng_stats[(e*NUM_STATS+k)*64 +: 64];
        end
    end

    always_comb begin
        state_nxt = state;
        abort_req = 1'b0;
        no_mask   = 1'b0;
        case (state)
            IDLE:
                if (caep00_p1) begin
                    if (mask != '0) state_nxt = START;
                    else            no_mask   = 1'b1;
                end
            START:   state_nxt = RUN;
            RUN:
                if (caep01 || timeout_hit) begin
                    abort_req = 1'b1;
                    state_nxt = IDLE;
                end else if ((done_now & mask) == mask) begin
                    state_nxt = COLLECT;
                end
            COLLECT: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control/response stage: everything here is registered one cycle after its cause.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state             <= IDLE;
            caep00_p1         <= 1'b0;
            done_q            <= '0;
            eng_abort         <= '0;
            disp_exception    <= '0;
            disp_rtn_data_vld <= 1'b0;
            disp_rtn_data     <= '0;
            csr_rd_ack        <= 1'b0;
            csr_rd_data       <= '0;
        end else begin
            state     <= state_nxt;
            caep00_p1 <= caep00;
            if (state == START)
                done_q <= '0;
            else if (state == RUN)
                done_q <= done_now;
            eng_abort      <= abort_req ? mask : '0;
            disp_exception <= {11'b0, timeout_hit, abort_req, no_mask,
                               (disp_aeg_rd || disp_aeg_wr) && !idx_ok,
                               disp_inst_vld && (disp_inst > 5'd1)};
            disp_rtn_data_vld <= disp_aeg_rd;
            disp_rtn_data     <= (disp_aeg_rd && idx_ok) ? aeg[idx] : '0;
            csr_rd_ack        <= csr_rd_vld;
            case (csr_address)
                16'd0:   csr_rd_data <= {61'b0, state};
                16'd1:   csr_rd_data <= aeg[6];
                16'd2:   csr_rd_data <= 64'(done_q);
                default: csr_rd_data <= '0;
            endcase
        end
    end

    // Result writes go first so a same-cycle dispatch write to the same AEG wins.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < NA; i++)
                aeg[i] <= '0;
        end else begin
            if (state == COLLECT) begin
                aeg[6] <= {48'b0, gvt_min};
                for (int k = 0; k < NUM_STATS; k++)
                    aeg[7+k] <= stat_sum[k];
            end
            if (disp_aeg_wr && idx_ok)
                aeg[idx] <= disp_aeg_wr_data;
        end
    end
endmodule

// File: tb/tb_pdes_disp_ctl.sv
// Self-checking bench for pdes_disp_ctl: vector table for AEG access/exceptions, sequences for engine runs.
module tb_pdes_disp_ctl;
    localparam int NA = 16;
    localparam int NE = 4;
    localparam int NS = 5;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              disp_inst_vld;
    logic [4:0]        disp_inst;
    logic [17:0]       disp_aeg_idx;
    logic              disp_aeg_rd, disp_aeg_wr;
    logic [63:0]       disp_aeg_wr_data;
    logic [17:0]       disp_aeg_cnt;
    logic [15:0]       disp_exception;
    logic              disp_idle, disp_stall, disp_rtn_data_vld;
    logic [63:0]       disp_rtn_data;
    logic [NE-1:0]     eng_start, eng_abort, eng_done;
    logic [NE*16-1:0]  eng_gvt;
    logic [NE*NS*64-1:0] eng_stats;
    logic [255:0]      eng_cfg;
    logic              csr_rd_vld, csr_rd_ack;
    logic [15:0]       csr_address;
    logic [63:0]       csr_rd_data;

    pdes_disp_ctl #(.NA(NA), .NUM_ENG(NE), .NUM_STATS(NS)) dut (
        .clk(clk), .i_reset(i_reset),
        .disp_inst_vld(disp_inst_vld), .disp_inst(disp_inst),
        .disp_aeg_idx(disp_aeg_idx), .disp_aeg_rd(disp_aeg_rd),
        .disp_aeg_wr(disp_aeg_wr), .disp_aeg_wr_data(disp_aeg_wr_data),
        .disp_aeg_cnt(disp_aeg_cnt), .disp_exception(disp_exception),
        .disp_idle(disp_idle), .disp_stall(disp_stall),
        .disp_rtn_data_vld(disp_rtn_data_vld), .disp_rtn_data(disp_rtn_data),
        .eng_start(eng_start), .eng_abort(eng_abort), .eng_done(eng_done),
        .eng_gvt(eng_gvt), .eng_stats(eng_stats), .eng_cfg(eng_cfg),
        .csr_rd_vld(csr_rd_vld), .csr_address(csr_address),
        .csr_rd_ack(csr_rd_ack), .csr_rd_data(csr_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ivld;
        logic [4:0]  inst;
        logic        rd;
        logic        wr;
        logic [17:0] idx;
        logic [63:0] wd;
        logic [63:0] rtn;
        logic [15:0] exc;
    } vec_t;

    vec_t        vecs[12];
    logic [63:0] rtn_q[$];
    logic [63:0] csr_q[$];
    int          total = 0;
    int          bad = 0;
    logic [NE-1:0] start_seen, abort_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and observe the registered outputs just after the edge.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        start_seen |= eng_start;
        abort_seen |= eng_abort;
        if (disp_rtn_data_vld === 1'b1) begin
            if (rtn_q.size() == 0) check("rtn_unexpected", 64'd1, 64'd0);
            else begin
                e = rtn_q.pop_front();
                check("rtn_data", disp_rtn_data, e);
            end
        end
        if (csr_rd_ack === 1'b1) begin
            if (csr_q.size() == 0) check("csr_unexpected", 64'd1, 64'd0);
            else begin
                e = csr_q.pop_front();
                check("csr_data", csr_rd_data, e);
            end
        end
    endtask

    task automatic aeg_wr(input int i, input logic [63:0] d);
        disp_aeg_idx = 18'(i); disp_aeg_wr_data = d; disp_aeg_wr = 1'b1;
        tick();
        disp_aeg_wr = 1'b0;
    endtask

    task automatic aeg_rd(input int i, input logic [63:0] exp);
        disp_aeg_idx = 18'(i); disp_aeg_rd = 1'b1; rtn_q.push_back(exp);
        tick();
        disp_aeg_rd = 1'b0;
    endtask

    task automatic csr_rd(input int a, input logic [63:0] exp);
        csr_address = 16'(a); csr_rd_vld = 1'b1; csr_q.push_back(exp);
        tick();
        csr_rd_vld = 1'b0;
    endtask

    task automatic caep(input int op);
        disp_inst = 5'(op); disp_inst_vld = 1'b1;
        tick();
        disp_inst_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 10 && disp_idle !== 1'b1; n++) tick();
        check(name, 64'(disp_idle), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 1'b0, 1'b1, 18'd8,  64'hDEAD_BEEF_0000_0001, 64'h0, 16'h0};
        vecs[1]  = '{1'b0, 5'd0, 1'b1, 1'b0, 18'd8,  64'h0, 64'hDEAD_BEEF_0000_0001, 16'h0};
        vecs[2]  = '{1'b0, 5'd0, 1'b1, 1'b1, 18'd8,  64'h55, 64'hDEAD_BEEF_0000_0001, 16'h0};
        vecs[3]  = '{1'b0, 5'd0, 1'b1, 1'b0, 18'd8,  64'h0, 64'h55, 16'h0};
        vecs[4]  = '{1'b0, 5'd0, 1'b1, 1'b0, 18'd20, 64'h0, 64'h0, 16'h2};
        vecs[5]  = '{1'b0, 5'd0, 1'b0, 1'b1, 18'd17, 64'h1, 64'h0, 16'h2};
        vecs[6]  = '{1'b0, 5'd0, 1'b1, 1'b0, 18'd0,  64'h0, 64'h0, 16'h0};
        vecs[7]  = '{1'b0, 5'd0, 1'b0, 1'b1, 18'd0,  64'h1234, 64'h0, 16'h0};
        vecs[8]  = '{1'b0, 5'd0, 1'b1, 1'b0, 18'd0,  64'h0, 64'h1234, 16'h0};
        vecs[9]  = '{1'b0, 5'd0, 1'b1, 1'b0, 18'd15, 64'h0, 64'h0, 16'h0};
        vecs[10] = '{1'b1, 5'd3, 1'b0, 1'b0, 18'd0,  64'h0, 64'h0, 16'h1};
        vecs[11] = '{1'b1, 5'd31, 1'b1, 1'b0, 18'd16, 64'h0, 64'h0, 16'h3};

        i_reset = 1'b1; disp_inst_vld = 1'b0; disp_inst = '0; disp_aeg_idx = '0;
        disp_aeg_rd = 1'b0; disp_aeg_wr = 1'b0; disp_aeg_wr_data = '0;
        eng_done = '0; eng_gvt = '0; eng_stats = '0; csr_rd_vld = 1'b0; csr_address = '0;
        start_seen = '0; abort_seen = '0;
        repeat (3) tick();
        i_reset = 1'b0;
        check("rst_idle", 64'(disp_idle), 64'd1);
        check("rst_stall", 64'(disp_stall), 64'd0);
        check("rst_start", 64'(eng_start), 64'd0);
        check("rst_abort", 64'(eng_abort), 64'd0);
        check("rst_exc", 64'(disp_exception), 64'd0);
        check("rst_rtn_vld", 64'(disp_rtn_data_vld), 64'd0);
        check("rst_csr_ack", 64'(csr_rd_ack), 64'd0);
        check("aeg_cnt", 64'(disp_aeg_cnt), 64'd16);

        for (int v = 0; v < 12; v++) begin
            disp_inst_vld = vecs[v].ivld; disp_inst = vecs[v].inst;
            disp_aeg_rd = vecs[v].rd; disp_aeg_wr = vecs[v].wr;
            disp_aeg_idx = vecs[v].idx; disp_aeg_wr_data = vecs[v].wd;
            if (vecs[v].rd) rtn_q.push_back(vecs[v].rtn);
            tick();
            check($sformatf("vec%0d_exc", v), 64'(disp_exception), 64'(vecs[v].exc));
            disp_inst_vld = 1'b0; disp_aeg_rd = 1'b0; disp_aeg_wr = 1'b0;
        end
        check("cfg_aeg0", eng_cfg[63:0], 64'h1234);

        // All four engines, staggered completion.
        eng_gvt = {16'd90, 16'd33, 16'd25, 16'd40};
        aeg_wr(4, 64'hF);
        start_seen = '0;
        caep(0);
        check("caep_not_idle", 64'(disp_idle), 64'd0);
        check("caep_stall", 64'(disp_stall), 64'd1);
        tick();
        check("start_all", 64'(eng_start), 64'hF);
        tick();
        check("start_one_cycle", 64'(eng_start), 64'd0);
        for (int c = 1; c <= 20; c++) begin
            eng_done = {c == 20, c == 15, c == 12, c == 10};
            if (c == 5) begin
                csr_address = 16'd0; csr_rd_vld = 1'b1; csr_q.push_back(64'd2);
            end
            tick();
            csr_rd_vld = 1'b0;
        end
        eng_done = '0;
        check("run_busy", 64'(disp_idle), 64'd0);
        csr_rd(0, 64'd3);
        wait_idle("idle_after_all");
        check("start_mask_seen", 64'(start_seen), 64'hF);
        aeg_rd(6, 64'd25);
        csr_rd(1, 64'd25);
        csr_rd(2, 64'hF);

        // Engines 0 and 2 only; statistic 0 wraps.
        eng_stats = '0;
        eng_stats[0*64 +: 64]        = 64'hFFFF_FFFF_FFFF_FFFF;
        eng_stats[(1*NS)*64 +: 64]   = 64'd100;
        eng_stats[(2*NS)*64 +: 64]   = 64'd2;
        eng_stats[(3*NS)*64 +: 64]   = 64'd7;
        eng_stats[1*64 +: 64]        = 64'd10;
        eng_stats[(1*NS+1)*64 +: 64] = 64'd1000;
        eng_stats[(2*NS+1)*64 +: 64] = 64'd20;
        aeg_wr(4, 64'h5);
        caep(0);
        tick();
        check("start_mask5", 64'(eng_start), 64'h5);
        tick();
        eng_done = 4'b1010;
        tick();
        eng_done = '0;
        tick(); tick();
        check("unmasked_done_ignored", 64'(disp_idle), 64'd0);
        csr_rd(0, 64'd2);
        csr_rd(2, 64'hA);
        eng_done = 4'b0101;
        tick();
        eng_done = '0;
        wait_idle("idle_after_mask5");
        aeg_rd(7, 64'd1);
        aeg_rd(8, 64'd30);
        aeg_rd(6, 64'd33);

        // Empty mask.
        aeg_wr(4, 64'h0);
        start_seen = '0;
        caep(0);
        tick();
        check("nomask_exc", 64'(disp_exception), 64'h4);
        check("nomask_idle", 64'(disp_idle), 64'd1);
        tick(); tick();
        check("nomask_exc_clear", 64'(disp_exception), 64'h0);
        check("nomask_no_start", 64'(start_seen), 64'h0);

        // Abort while running.
        aeg_wr(4, 64'hF);
        caep(0);
        tick(); tick(); tick(); tick();
        caep(1);
        check("abort_mask", 64'(eng_abort), 64'hF);
        check("abort_exc", 64'(disp_exception), 64'h8);
        check("abort_idle", 64'(disp_idle), 64'd1);
        tick();
        check("abort_one_cycle", 64'(eng_abort), 64'h0);
        aeg_rd(6, 64'd33);
        abort_seen = '0;
        caep(1);
        check("caep01_idle_exc", 64'(disp_exception), 64'h0);
        check("caep01_idle_noabort", 64'(abort_seen), 64'h0);

        // Reset in the middle of a run.
        aeg_wr(4, 64'h3);
        caep(0);
        tick(); tick();
        abort_seen = '0;
        i_reset = 1'b1;
        tick();
        check("rst_run_abort", 64'(eng_abort), 64'h0);
        check("rst_run_idle", 64'(disp_idle), 64'd1);
        check("rst_run_stall", 64'(disp_stall), 64'd0);
        i_reset = 1'b0;
        tick();
        check("rst_run_no_abort", 64'(abort_seen), 64'h0);
        aeg_rd(4, 64'd0);
        csr_rd(0, 64'd0);

`ifdef PDES_DISP_TIMEOUT_EN
        begin
            int n;
            n = 0;
            aeg_wr(5, 64'd100);
            aeg_wr(4, 64'h1);
            caep(0);
            tick(); tick();
            for (int k = 1; k <= 300; k++) begin
                tick();
                if (eng_abort != '0) begin
                    n = k;
                    break;
                end
            end
            check("timeout_cycles", 64'(n), 64'd100);
            check("timeout_exc", 64'(disp_exception), 64'h18);
            check("timeout_abort", 64'(eng_abort), 64'h1);
        end
`endif

        tick();
        check("rtn_q_drained", 64'(rtn_q.size()), 64'd0);
        check("csr_q_drained", 64'(csr_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pdes_disp_ctl.md
PDES_DISP_CTL -- requirements
Module: pdes_disp_ctl

Interface
REQ-001 SHALL have parameter NA, default 16, number of AEG registers; power of 2, 16..64.
REQ-002 SHALL have parameter NUM_ENG, default 4, number of simulation engines; 1..8.
REQ-003 SHALL have parameter NUM_STATS, default 5, number of 64-bit statistics words per engine; requires NA >= 7+NUM_STATS.
REQ-004 SHALL have port: clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port: i_reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have dispatch inputs: disp_inst_vld 1, disp_inst 5, disp_aeg_idx 18, disp_aeg_rd 1, disp_aeg_wr 1, disp_aeg_wr_data 64.
REQ-007 SHALL have dispatch outputs: disp_aeg_cnt 18 (constant NA), disp_exception 16, disp_idle 1, disp_stall 1, disp_rtn_data_vld 1, disp_rtn_data 64.
REQ-008 SHALL have engine ports: eng_start out NUM_ENG, eng_abort out NUM_ENG, eng_done in NUM_ENG, eng_gvt in NUM_ENG*16, eng_stats in NUM_ENG*NUM_STATS*64, eng_cfg out 256 (AEG0..3 flattened, AEG0 in LSBs).
REQ-009 SHALL have CSR ports: csr_rd_vld in 1, csr_address in 16, csr_rd_ack out 1, csr_rd_data out 64.

Function
REQ-010 AEG map SHALL be: 0..3 engine config, 4 engine mask [NUM_ENG-1:0], 5 timeout cycles, 6 GVT result, 7..7+NUM_STATS-1 statistics results; others general scratch.
REQ-011 AEG read SHALL return data with disp_rtn_data_vld one cycle after disp_aeg_rd; index >= NA returns 0.
REQ-012 Read and write to the same index in one cycle SHALL return the pre-write value.
REQ-013 A dispatch write SHALL take priority over a result write to the same AEG in the same cycle.
REQ-014 FSM states SHALL be IDLE, START, RUN, COLLECT, DONE.
REQ-015 IDLE->START on registered caep00 (disp_inst_vld, disp_inst==0) if AEG4 masked to NUM_ENG bits is nonzero; if zero, stay IDLE and pulse disp_exception[2].
REQ-016 START SHALL pulse eng_start = mask for exactly one cycle, clear sticky done bits, then go to RUN.
REQ-017 RUN SHALL OR eng_done into sticky done bits; when (done & mask)==mask go to COLLECT; unmasked engines' done ignored.
REQ-018 COLLECT (one cycle) SHALL write AEG6 = {48'b0, min of eng_gvt over masked engines} and AEG(7+k) = 64-bit wrap-around sum of stat word k over masked engines; then DONE.
REQ-019 DONE SHALL last one cycle, then IDLE.
REQ-020 caep01 in RUN SHALL pulse eng_abort = mask one cycle, pulse disp_exception[3], go to IDLE without updating result AEGs; caep01 in any other state is a no-op.
REQ-021 disp_inst_vld with disp_inst not 0 or 1 SHALL pulse disp_exception[0] one cycle later; AEG rd/wr with idx >= NA SHALL pulse disp_exception[1] one cycle later; unused exception bits 0.
REQ-022 disp_idle SHALL be (state==IDLE) and no registered caep00; disp_stall SHALL be (state!=IDLE) or caep00 this cycle or previous cycle.
REQ-023 CSR read SHALL ack one cycle after csr_rd_vld; address 0 returns {61'b0, state}, 1 returns AEG6, 2 returns sticky done bits, others 0.

Reset
REQ-024 On i_reset: state IDLE; all AEGs 0; eng_start, eng_abort, disp_exception, disp_rtn_data_vld, csr_rd_ack 0; disp_rtn_data, csr_rd_data 0; done bits 0; disp_idle 1, disp_stall 0 the cycle after.
REQ-025 Reset mid-RUN SHALL return to IDLE without pulsing eng_abort.

Configuration
REQ-026 Macro PDES_DISP_TIMEOUT_EN: when defined, a 32-bit counter SHALL clear in START, increment each RUN cycle, and on reaching AEG5[31:0] (nonzero) act as abort (REQ-020) plus pulse disp_exception[4]; when undefined, no counter, AEG5 is scratch, exception[4] is 0.

Verification
REQ-027 Write AEG4=0xF, caep00, engines assert done on cycles 10,12,15,20 with gvt 40,25,33,90 -> COLLECT after last done, AEG6 reads 25, idle restored.
REQ-028 AEG4=0x5, only engines 0,2 done, stats 0xFFFF_FFFF_FFFF_FFFF and 2 -> AEG7 reads 1 (wrap), engine 1/3 done ignored.
REQ-029 AEG4=0, caep00 -> exception[2] pulse, eng_start never asserted, disp_idle returns 1.
REQ-030 caep01 during RUN -> eng_abort=mask one cycle, exception[3], AEG6 unchanged.
REQ-031 Read AEG idx 20 (NA=16) -> rtn data 0, exception[1]; disp_inst=3 -> exception[0].
REQ-032 With PDES_DISP_TIMEOUT_EN, AEG5=100, no done -> abort plus exception[4] after 100 RUN cycles.
